// File: rtl/muxn_stream_pkg.sv
// Shared definitions for the muxn_stream channel multiplexer.
package mux_pkg;

  // Arbitration mode encodings.
  localparam logic MODE_SEL = 1'b0;  // external select
  localparam logic MODE_RR  = 1'b1;  // round-robin

endpackage

// File: rtl/muxn_stream_if.sv
// Stream bundle for muxn_stream: NCH input channels in, one registered channel out.
interface muxn_stream_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SW    = $clog2(NCH)
) ();

  logic                 mode;
  logic [SW-1:0]        s;
  logic [NCH*WIDTH-1:0] a;
  logic [NCH-1:0]       a_valid;
  logic [NCH-1:0]       a_ready;
  logic [WIDTH-1:0]     y;
  logic [SW-1:0]        y_ch;
  logic                 y_valid;
  logic                 y_ready;

  // Side that produces channel data and consumes y.
  modport master (
    output mode, s, a, a_valid, y_ready,
    input  a_ready, y, y_ch, y_valid
  );

  // The multiplexer itself.
  modport slave (
    input  mode, s, a, a_valid, y_ready,
    output a_ready, y, y_ch, y_valid
  );

endinterface

// File: rtl/muxn_stream_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr_i, wrapping modulo NCH.
module rr_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [SW-1:0]  ptr_i,
  output logic [NCH-1:0] grant_o,
  output logic [SW-1:0]  idx_o,
  output logic           any_o
);

  localparam logic [SW:0] NchW = (SW+1)'(NCH);

  // One extra bit so ptr + offset (at most 2*NCH-2) never overflows before the wrap.
  logic [SW:0] chan;

  // Scan offsets from the farthest to the nearest so the nearest requester wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    chan    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      chan = {1'b0, ptr_i} + (SW+1)'(k);
      if (chan >= NchW) begin
        chan = chan - NchW;
      end
      if (req_i[chan[SW-1:0]]) begin
        idx_o = chan[SW-1:0];
        any_o = 1'b1;
      end
    end
    if (any_o) begin
      grant_o = NCH'(1) << idx_o;
    end
  end

endmodule

// File: rtl/muxn_stream.sv
// N-channel stream multiplexer with external-select or round-robin arbitration
// and a single registered output stage sustaining one word per cycle.
module muxn_stream
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SW    = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  muxn_stream_if.slave  bus
);

  localparam int unsigned SelSpan = 2 ** SW;
  localparam logic [SW-1:0] LastCh = SW'(NCH - 1);

  logic [WIDTH-1:0] ch_data [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_split
    assign ch_data[i] = bus.a[i*WIDTH +: WIDTH];
  end

  logic [WIDTH-1:0] y_q, y_d;
  logic [SW-1:0]    y_ch_q, y_ch_d;
  logic             y_valid_q, y_valid_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic [NCH-1:0]     rr_grant;
  logic [SW-1:0]      rr_idx;
  logic               rr_any;
  logic [SelSpan-1:0] valid_ext;
  logic               sel_any;
  logic [NCH-1:0]     g_vec;
  logic [SW-1:0]      g_idx;
  logic               g_any;
  logic               load;

  rr_arbiter #(
    .NCH (NCH),
    .SW  (SW)
  ) u_rr_arbiter (
    .req_i   (bus.a_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  // Zero-padding valid to the full select range makes out-of-range selects grant nothing.
  assign valid_ext = SelSpan'(bus.a_valid);
  assign sel_any   = valid_ext[bus.s];
  assign load      = !y_valid_q || bus.y_ready;

  // Grant mux: pick the grant source for the current mode.
  always_comb begin
    g_any = sel_any;
    g_idx = bus.s;
    g_vec = sel_any ? (NCH'(1) << bus.s) : '0;
    if (bus.mode == MODE_RR) begin
      g_any = rr_any;
      g_idx = rr_idx;
      g_vec = rr_grant;
    end
  end

  // Accept strobe only when the output register can take a word this cycle.
  always_comb begin
    bus.a_ready = load ? g_vec : '0;
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    if (load) begin
      if (g_any) begin
        y_d       = ch_data[g_idx];
        y_ch_d    = g_idx;
        y_valid_d = 1'b1;
        if (bus.mode == MODE_RR) begin
          ptr_d = (g_idx == LastCh) ? '0 : g_idx + 1'b1;
        end
      end else begin
        // Data and index are left stale; only the valid flag drops.
        y_valid_d = 1'b0;
      end
    end
  end

  // Output register and pointer, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_ch    = y_ch_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_muxn_stream.sv
// Self-checking bench for muxn_stream: a 4-channel and a 3-channel instance driven
// with the same stimulus and compared against a behavioural model each cycle.
module tb_muxn_stream;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        tb_mode;
  logic [1:0]  tb_s;
  logic [31:0] tb_a [4];
  logic [3:0]  tb_valid;
  logic        tb_y_ready;

  int n_checks = 0;
  int n_fail   = 0;

  muxn_stream_if #(.WIDTH(32), .NCH(4)) if4 ();
  muxn_stream_if #(.WIDTH(32), .NCH(3)) if3 ();

  assign if4.mode    = tb_mode;
  assign if4.s       = tb_s;
  assign if4.a       = {tb_a[3], tb_a[2], tb_a[1], tb_a[0]};
  assign if4.a_valid = tb_valid;
  assign if4.y_ready = tb_y_ready;
  assign if3.mode    = tb_mode;
  assign if3.s       = tb_s;
  assign if3.a       = {tb_a[2], tb_a[1], tb_a[0]};
  assign if3.a_valid = tb_valid[2:0];
  assign if3.y_ready = tb_y_ready;

  muxn_stream #(.WIDTH(32), .NCH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  muxn_stream #(.WIDTH(32), .NCH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // Behavioural model: index 0 is the 4-channel instance, index 1 the 3-channel one.
  logic [31:0] m_y   [2];
  int          m_ych [2];
  logic        m_yv  [2];
  int          m_ptr [2];

  function automatic int nch(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic bit is_valid(int c);
    return ((tb_valid >> c) & 4'd1) != 4'd0;
  endfunction

  // Channel the rules say is granted this cycle, or -1 for none.
  function automatic int model_grant(int k);
    int n = nch(k);
    if (tb_mode == MODE_SEL) begin
      if (int'(tb_s) < n && is_valid(int'(tb_s))) return int'(tb_s);
      return -1;
    end
    for (int j = 0; j < n; j++) begin
      int c = (m_ptr[k] + j) % n;
      if (is_valid(c)) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int k);
    int g = model_grant(k);
    if ((!m_yv[k] || tb_y_ready) && g >= 0) return 4'(1 << g);
    return 4'd0;
  endfunction

  function automatic logic [34:0] exp_out(int k);
    return {m_yv[k], 2'(m_ych[k]), m_y[k]};
  endfunction

  function automatic logic [34:0] act_out(int k);
    return (k == 0) ? {if4.y_valid, if4.y_ch, if4.y} : {if3.y_valid, if3.y_ch, if3.y};
  endfunction

  function automatic logic [3:0] act_ready(int k);
    return (k == 0) ? if4.a_ready : {1'b0, if3.a_ready};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_y[k] = '0; m_ych[k] = 0; m_yv[k] = 1'b0; m_ptr[k] = 0;
    end
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        int g  = model_grant(k);
        bit ld = !m_yv[k] || tb_y_ready;
        if (ld) begin
          if (g >= 0) begin
            m_y[k] = tb_a[g]; m_ych[k] = g; m_yv[k] = 1'b1;
            if (tb_mode == MODE_RR) m_ptr[k] = (g + 1) % nch(k);
          end else begin
            m_yv[k] = 1'b0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tb_mode = MODE_SEL; tb_s = 2'd0; tb_valid = 4'd0; tb_y_ready = 1'b0;
    for (int i = 0; i < 4; i++) tb_a[i] = 32'hdead_0000 + 32'(i);
    #2 rst_n = 1'b0;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act_out(k) !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_out nch=%0d got=%h exp=0", nch(k), act_out(k));
      end
      n_checks++;
      if (act_ready(k) !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_ready nch=%0d got=%b exp=0000", nch(k), act_ready(k));
      end
    end
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_sel();
    tb_mode = MODE_SEL; tb_s = 2'd2; tb_valid = 4'hf; tb_y_ready = 1'b1;
    for (int i = 0; i < 4; i++) tb_a[i] = 32'(i);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act_ready(k) !== 4'b0100) begin
        n_fail++;
        $display("FAIL sel_ready nch=%0d got=%b exp=0100", nch(k), act_ready(k));
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act_out(k) !== {1'b1, 2'd2, 32'd2}) begin
        n_fail++;
        $display("FAIL sel_out nch=%0d got=%h exp=%h", nch(k), act_out(k), {1'b1, 2'd2, 32'd2});
      end
    end
  endtask

  task automatic test_rr();
    int seq4 [6] = '{0, 1, 2, 3, 0, 1};
    int seq3 [6] = '{0, 1, 2, 0, 1, 2};
    tb_mode = MODE_RR; tb_valid = 4'hf; tb_y_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++) tb_a[i] = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_ready(k) !== exp_ready(k)) begin
          n_fail++;
          $display("FAIL rr_ready nch=%0d cyc=%0d got=%b exp=%b", nch(k), c, act_ready(k),
                   exp_ready(k));
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        logic [34:0] want = {1'b1, 2'((k == 0) ? seq4[c] : seq3[c]), m_y[k]};
        n_checks++;
        if (act_out(k) !== want || exp_out(k) !== want) begin
          n_fail++;
          $display("FAIL rr_seq nch=%0d cyc=%0d got=%h exp=%h", nch(k), c, act_out(k), want);
        end
      end
    end
  endtask

  task automatic test_rr_sparse();
    int seq4 [3] = '{3, 1, 3};
    tb_mode = MODE_RR; tb_valid = 4'b1010; tb_y_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) tb_a[i] = $urandom;
      step();
      n_checks++;
      if (if4.y_ch !== 2'(seq4[c]) || if4.y_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_sparse_ch cyc=%0d got=%0d exp=%0d", c, if4.y_ch, seq4[c]);
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_out(k) !== exp_out(k)) begin
          n_fail++;
          $display("FAIL rr_sparse_out nch=%0d cyc=%0d got=%h exp=%h", nch(k), c, act_out(k),
                   exp_out(k));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    tb_mode = MODE_RR; tb_valid = 4'hf; tb_y_ready = 1'b1;
    for (int i = 0; i < 4; i++) tb_a[i] = $urandom;
    step();
    tb_y_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tb_mode = 1'($urandom); tb_s = 2'($urandom_range(0, 3)); tb_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) tb_a[i] = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_ready(k) !== 4'd0) begin
          n_fail++;
          $display("FAIL bp_ready nch=%0d cyc=%0d got=%b exp=0000", nch(k), c, act_ready(k));
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_out(k) !== exp_out(k)) begin
          n_fail++;
          $display("FAIL bp_hold nch=%0d cyc=%0d got=%h exp=%h", nch(k), c, act_out(k),
                   exp_out(k));
        end
      end
    end
    tb_y_ready = 1'b1; tb_mode = MODE_RR; tb_valid = 4'hf;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act_ready(k) !== exp_ready(k) || exp_ready(k) === 4'd0) begin
        n_fail++;
        $display("FAIL bp_release_ready nch=%0d got=%b exp=%b", nch(k), act_ready(k),
                 exp_ready(k));
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act_out(k) !== exp_out(k) || act_out(k) >> 34 !== 35'd1) begin
        n_fail++;
        $display("FAIL bp_reload nch=%0d got=%h exp=%h", nch(k), act_out(k), exp_out(k));
      end
    end
  endtask

  task automatic test_sel_oob();
    tb_mode = MODE_SEL; tb_s = 2'd3; tb_valid = 4'hf; tb_y_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) tb_a[i] = $urandom;
      #1;
      n_checks++;
      if (if3.a_ready !== 3'd0) begin
        n_fail++;
        $display("FAIL oob_ready cyc=%0d got=%b exp=000", c, if3.a_ready);
      end
      step();
      n_checks++;
      if (if3.y_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL oob_valid cyc=%0d got=%b exp=0", c, if3.y_valid);
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_out(k) !== exp_out(k)) begin
          n_fail++;
          $display("FAIL oob_out nch=%0d cyc=%0d got=%h exp=%h", nch(k), c, act_out(k),
                   exp_out(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      tb_mode = 1'($urandom); tb_s = 2'($urandom_range(0, 3)); tb_valid = 4'($urandom);
      tb_y_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) tb_a[i] = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_ready(k) !== exp_ready(k)) begin
          n_fail++;
          $display("FAIL rand_ready nch=%0d cyc=%0d got=%b exp=%b", nch(k), c, act_ready(k),
                   exp_ready(k));
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_out(k) !== exp_out(k)) begin
          n_fail++;
          $display("FAIL rand_out nch=%0d cyc=%0d got=%h exp=%h", nch(k), c, act_out(k),
                   exp_out(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    tb_mode = MODE_RR; tb_valid = 4'hf; tb_y_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) tb_a[i] = $urandom;
      step();
    end
    #2 rst_n = 1'b0;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act_out(k) !== 35'd0) begin
        n_fail++;
        $display("FAIL midreset_out nch=%0d got=%h exp=0", nch(k), act_out(k));
      end
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tb_a[i] = $urandom;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act_ready(k) !== 4'b0001) begin
        n_fail++;
        $display("FAIL midreset_ready nch=%0d got=%b exp=0001", nch(k), act_ready(k));
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act_out(k) !== {1'b1, 2'd0, tb_a[0]}) begin
        n_fail++;
        $display("FAIL midreset_restart nch=%0d got=%h exp=%h", nch(k), act_out(k),
                 {1'b1, 2'd0, tb_a[0]});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sel();
    test_rr();
    test_rr_sparse();
    test_backpressure();
    test_sel_oob();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muxn_stream.md
MUXN_STREAM -- requirements
Module: muxn_stream

Interface
REQ-001 Parameter WIDTH, default 32, is the data width per channel.
REQ-002 Parameter NCH, default 4, is the channel count (2..16).
REQ-003 Parameter SW, default $clog2(NCH), is the select/index width.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-006 mode  input  1  selects arbitration: 0 = SEL (external select), 1 = RR (round-robin).
REQ-007 s  input  SW  is the channel select, used in SEL mode only.
REQ-008 a  input  NCH*WIDTH  carries channel data; channel i is a[i*WIDTH +: WIDTH].
REQ-009 a_valid  input  NCH  holds per-channel data-valid flags.
REQ-010 a_ready  output  NCH  is the per-channel accept strobe, combinational.
REQ-011 y  output  WIDTH  is the registered output data.
REQ-012 y_ch  output  SW  is the registered index of the channel that supplied y.
REQ-013 y_valid  output  1  flags that the output register holds data.
REQ-014 y_ready  input  1  is downstream acceptance of y.

Function
REQ-015 A transfer out occurs in a cycle where y_valid && y_ready.
REQ-016 load = !y_valid || y_ready.
REQ-017 Grant in SEL mode: channel s, only when s < NCH and a_valid[s] = 1; otherwise no grant.
REQ-018 Grant in RR mode: first i with a_valid[i] = 1, scanning ptr, ptr+1, ... modulo NCH; no grant when a_valid = 0.
REQ-019 a_ready[i] = load && grant[i]; at most one bit of a_ready is set per cycle.
REQ-020 On a granted load, y <= a[g], y_ch <= g and y_valid <= 1 at the next edge, giving 1-cycle latency from input accept.
REQ-021 On load with no grant, y_valid <= 0 while y and y_ch hold their values.
REQ-022 With !load, y, y_ch and y_valid hold, and a_ready = 0 (backpressure).
REQ-023 Simultaneous drain and granted load: y is replaced, y_valid stays 1, and no bubble is inserted, so throughput is 1 word/cycle.
REQ-024 ptr (SW bits) <= (g+1) mod NCH on each RR-mode granted load only; wrap from NCH-1 to 0.
REQ-025 ptr is unchanged in SEL mode; a mode change takes effect on the same cycle's grant, and ptr is not cleared.
REQ-026 Changing s or mode while y_valid && !y_ready does not alter y or y_ch.

Reset
REQ-027 While rst_n = 0: y_valid = 0, y = 0, y_ch = 0, ptr = 0, asynchronously.
REQ-028 After the rst_n deassertion edge, the first grant is possible in the same cycle; RR starts scanning from channel 0.
REQ-029 Reset mid-operation discards the held word with no transfer signalled.

Structure
REQ-030 Shared package mux_pkg SHALL hold mode constants MODE_SEL = 1'b0 and MODE_RR = 1'b1.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs grant one-hot, idx, any).
REQ-032 The top level contains only the grant mux, the output register and ptr.

Verification
REQ-033 Bench SHALL cover each scenario below at WIDTH=32, NCH=4 and at NCH=3.
REQ-034 SEL, a0..a3 = 0,1,2,3, s=2, all valid, y_ready=1 -> a_ready=4'b0100; next cycle y=2, y_ch=2, y_valid=1.
REQ-035 RR, all valid, y_ready=1 for 6 cycles -> y_ch sequence 0,1,2,3,0,1 with y_valid continuously 1.
REQ-036 RR, a_valid=4'b1010, ptr=2 -> grant channel 3, then channel 1, then 3.
REQ-037 y_valid=1, y_ready=0 for 3 cycles -> a_ready=0, y stable; y_ready=1 -> drain and reload in the same cycle.
REQ-038 NCH=3, SEL, s=3 -> no grant, y_valid falls after drain.
REQ-039 rst_n pulsed low mid-stream -> y_valid=0 immediately; after release, RR restarts at channel 0.
